// File: rtl/ir_pkg.sv
// ir_pkg: shared NEC IR constants, state encoding, default widths and mark-state helper
package ir_pkg;
  localparam int CNT_W_DEF = 18;
  localparam int CAR_W_DEF = 12;
  localparam int NEC_BITS = 32;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LEAD_M = 3'd1;
  localparam logic [2:0] LEAD_S = 3'd2;
  localparam logic [2:0] BIT_M = 3'd3;
  localparam logic [2:0] BIT_S = 3'd4;
  localparam logic [2:0] STOP_M = 3'd5;
  localparam logic [2:0] DONE = 3'd6;
  function automatic logic is_mark(input logic [2:0] s);
    return s == LEAD_M || s == BIT_M || s == STOP_M;
  endfunction
endpackage

// File: rtl/ir_tx_if.sv
// ir_tx_if: tx handshake bundle (start/repeat/data/int_clr in, busy/int out); master drives, slave is ir_tx
interface ir_tx_if;
  logic tx_start;
  logic tx_repeat;
  logic [31:0] tx_data;
  logic tx_int_clr;
  logic tx_busy;
  logic tx_int;
  modport master(output tx_start, tx_repeat, tx_data, tx_int_clr, input tx_busy, tx_int);
  modport slave(input tx_start, tx_repeat, tx_data, tx_int_clr, output tx_busy, tx_int);
endinterface

// File: rtl/ir_carrier_gen.sv
// ir_carrier_gen: carrier counter 0..period restarting high on restart; ports clk, rstn, restart, period, high, car
module ir_carrier_gen import ir_pkg::*; #(
  parameter int CAR_W = CAR_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             restart,
  input  logic [CAR_W-1:0] period,
  input  logic [CAR_W-1:0] high,
  output logic             car
);
  logic [CAR_W-1:0] car_cnt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) car_cnt <= '0;
    else car_cnt <= restart || car_cnt >= period ? '0 : car_cnt + CAR_W'(1);
  assign car = car_cnt < high;
endmodule

// File: rtl/ir_tx.sv
// ir_tx: NEC IR frame transmitter; ports clk, rstn, bus (start/repeat/data/int_clr/busy/int), rf_* timing/carrier config, sout
module ir_tx import ir_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int CAR_W = CAR_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  ir_tx_if.slave           bus,
  input  logic             rf_ir_phase,
  input  logic             rf_carr_en,
  input  logic [CAR_W-1:0] rf_carr_period,
  input  logic [CAR_W-1:0] rf_carr_high,
  input  logic [CNT_W-1:0] rf_9ms_cnt,
  input  logic [CNT_W-1:0] rf_4p5_cnt,
  input  logic [CNT_W-1:0] rf_2p25_cnt,
  input  logic [CNT_W-1:0] rf_0p56_cnt,
  input  logic [CNT_W-1:0] rf_1p69_cnt,
  output logic             sout
);
  logic [2:0] state, state_nxt;
  logic [CNT_W-1:0] dur_cnt, tgt_raw, tgt;
  logic [31:0] shift;
  logic [5:0] bit_cnt;
  logic rep, ph_end, car, mod;
  always_comb begin
    tgt_raw = state == LEAD_M ? rf_9ms_cnt :
              state == LEAD_S ? (rep ? rf_2p25_cnt : rf_4p5_cnt) :
              state == BIT_S && shift[0] ? rf_1p69_cnt : rf_0p56_cnt;
    tgt = tgt_raw == '0 ? CNT_W'(1) : tgt_raw;
    ph_end = dur_cnt == tgt - CNT_W'(1);
    state_nxt = state == IDLE ? (bus.tx_start ? LEAD_M : IDLE) :
                state == DONE ? IDLE :
                !ph_end ? state :
                state == LEAD_M ? LEAD_S :
                state == LEAD_S ? (rep ? STOP_M : BIT_M) :
                state == BIT_M ? BIT_S :
                state == BIT_S ? (bit_cnt == 6'(NEC_BITS - 1) ? STOP_M : BIT_M) :
                state == STOP_M ? DONE : IDLE;
    mod = is_mark(state) & (rf_carr_en ? car : 1'b1);
  end
  ir_carrier_gen #(.CAR_W(CAR_W)) u_car (
    .clk(clk),
    .rstn(rstn),
    .restart(is_mark(state_nxt) && state_nxt != state),
    .period(rf_carr_period),
    .high(rf_carr_high),
    .car(car)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      dur_cnt <= '0;
      shift <= '0;
      bit_cnt <= '0;
      rep <= 1'b0;
      sout <= 1'b0;
      bus.tx_busy <= 1'b0;
      bus.tx_int <= 1'b0;
    end else begin
      state <= state_nxt;
      bus.tx_busy <= state_nxt != IDLE;
      dur_cnt <= state_nxt != state ? '0 : &dur_cnt ? dur_cnt : dur_cnt + CNT_W'(1);
      if (state == IDLE && bus.tx_start) begin
        shift <= bus.tx_data;
        rep <= bus.tx_repeat;
        bit_cnt <= '0;
      end else if (state == BIT_S && ph_end) begin
        shift <= shift >> 1;
        bit_cnt <= bit_cnt + 6'd1;
      end
      sout <= rf_ir_phase ? ~mod : mod;
      bus.tx_int <= state == DONE || (bus.tx_int && !bus.tx_int_clr);
    end
endmodule
